// File: rtl/dec_ram_drain.sv
// Drains one frame of decision bits from a decision RAM bank and packs them LSB-first into an OUT_WIDTH stream.
// Optional feature: define DEC_DRAIN_PARITY_EN to add m_parity (XOR of the frame) on the m_last word.
module dec_ram_drain #(
   parameter int ADDR_WIDTH = 8,
   parameter int FRAME_LEN  = 256,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  start_bank,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_rs,
   input  logic                  ram_data,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
`ifdef DEC_DRAIN_PARITY_EN
   output logic                  m_parity,
`endif
   output logic                  busy,
   output logic                  done
);
   localparam int CNT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(OUT_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
   state_t state;

   logic [ADDR_WIDTH-1:0] addr;
   logic                  cap_valid;
   logic                  cap_last;
   logic [OUT_WIDTH-1:0]  pack_data;
   logic [CNT_W-1:0]      pack_cnt;
   logic                  pack_full;
   logic                  pack_last;

   logic                  hold_free;
   logic                  take;
   logic                  word_done;
   logic                  load_from_pack;
   logic                  load_from_cap;
   logic                  issue;
   logic [OUT_WIDTH-1:0]  word;

   // A completed word that cannot enter the holding register parks in the packing
   // register; issue stalls so no capture ever arrives while it is parked.
   always_comb begin
      hold_free      = !m_valid || m_ready;
      take           = cap_valid && !pack_full;
      word           = pack_data | (OUT_WIDTH'(ram_data) << pack_cnt);
      word_done      = take && (cap_last || (pack_cnt == LAST_BIT));
      load_from_pack = pack_full && hold_free;
      load_from_cap  = word_done && hold_free;
      issue          = (state == READ) && !pack_full && !(word_done && !hold_free);
   end

   assign ram_cs      = issue;
   assign ram_address = addr;
   assign ram_we      = 1'b0;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         ram_rs    <= 1'b0;
         cap_valid <= 1'b0;
         cap_last  <= 1'b0;
         pack_data <= '0;
         pack_cnt  <= '0;
         pack_full <= 1'b0;
         pack_last <= 1'b0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         cap_valid <= issue;
         cap_last  <= issue && (addr == LAST_ADDR);

         case (state)
            IDLE: begin
               if (start) begin
                  state  <= READ;
                  ram_rs <= start_bank;
                  addr   <= '0;
               end
            end
            READ: begin
               if (issue) begin
                  if (addr == LAST_ADDR) begin
                     state <= FLUSH;
                     addr  <= '0;
                  end else begin
                     addr <= addr + ADDR_WIDTH'(1);
                  end
               end
            end
            FLUSH: begin
               if (m_valid && m_ready && m_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (load_from_pack) begin
            pack_full <= 1'b0;
            pack_data <= '0;
            pack_cnt  <= '0;
         end else if (take) begin
            if (word_done) begin
               pack_cnt <= '0;
               if (hold_free) begin
                  pack_data <= '0;
               end else begin
                  pack_data <= word;
                  pack_full <= 1'b1;
                  pack_last <= cap_last;
               end
            end else begin
               pack_data <= word;
               pack_cnt  <= pack_cnt + CNT_W'(1);
            end
         end

         if (load_from_pack) begin
            m_data  <= pack_data;
            m_valid <= 1'b1;
            m_last  <= pack_last;
         end else if (load_from_cap) begin
            m_data  <= word;
            m_valid <= 1'b1;
            m_last  <= cap_last;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

`ifdef DEC_DRAIN_PARITY_EN
   logic par_acc;
   logic par_next;

   assign par_next = par_acc ^ (take & ram_data);

   // Running XOR over captured bits, cleared when a new frame is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_acc  <= 1'b0;
         m_parity <= 1'b0;
      end else begin
         if ((state == IDLE) && start) par_acc <= 1'b0;
         else                          par_acc <= par_next;

         if (load_from_pack)              m_parity <= pack_last & par_acc;
         else if (load_from_cap)          m_parity <= cap_last & par_next;
         else if (m_valid && m_ready)     m_parity <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_dec_ram_drain.sv
// Directed self-checking bench for dec_ram_drain: a 256-bit/8-bit instance and a 13-bit frame instance.
`timescale 1ns/1ps
module tb_dec_ram_drain;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_start, a_bank, a_cs, a_we, a_rs, a_rdata, a_valid, a_last, a_ready, a_busy, a_done;
   logic [7:0] a_addr, a_data;
   logic       b_start, b_bank, b_cs, b_we, b_rs, b_rdata, b_valid, b_last, b_ready, b_busy, b_done;
   logic [7:0] b_addr, b_data;
`ifdef DEC_DRAIN_PARITY_EN
   logic       a_par, b_par;
`endif

   dec_ram_drain dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .start_bank(a_bank),
      .ram_address(a_addr), .ram_cs(a_cs), .ram_we(a_we), .ram_rs(a_rs), .ram_data(a_rdata),
      .m_data(a_data), .m_valid(a_valid), .m_last(a_last), .m_ready(a_ready),
`ifdef DEC_DRAIN_PARITY_EN
      .m_parity(a_par),
`endif
      .busy(a_busy), .done(a_done)
   );

   dec_ram_drain #(.ADDR_WIDTH(8), .FRAME_LEN(13), .OUT_WIDTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .start_bank(b_bank),
      .ram_address(b_addr), .ram_cs(b_cs), .ram_we(b_we), .ram_rs(b_rs), .ram_data(b_rdata),
      .m_data(b_data), .m_valid(b_valid), .m_last(b_last), .m_ready(b_ready),
`ifdef DEC_DRAIN_PARITY_EN
      .m_parity(b_par),
`endif
      .busy(b_busy), .done(b_done)
   );

   logic [255:0] mem_a [2];
   logic [15:0]  mem_b;

   always @(posedge clk) if (a_cs) a_rdata <= mem_a[a_rs][a_addr];
   always @(posedge clk) if (b_cs) b_rdata <= mem_b[b_addr[3:0]];

   int checks = 0;
   int errors = 0;

   logic [7:0] words[$];
   logic       lasts[$];
   int done_cnt, done_j, stab_err, addr_err, pauses, rs_err, we_err, busy_err, issued;
   bit timeout;

   // Runs one frame on dut_a, recording accepted words and protocol observations.
   task automatic drain(input logic bank, input int duty, input int inject_at,
                        input bit prestarted, input bit chain_out);
      logic [7:0] pd;
      logic pv, pr, pl;
      words.delete();
      lasts.delete();
      done_cnt = 0; done_j = -1; stab_err = 0; addr_err = 0; pauses = 0;
      rs_err = 0; we_err = 0; busy_err = 0; issued = 0; timeout = 1'b1;
      pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
      if (!prestarted) begin
         @(negedge clk);
         a_start = 1'b1;
         a_bank  = bank;
      end
      for (int j = 0; j < 4000; j++) begin
         @(negedge clk);
         a_start = (j == inject_at);
         if (j == inject_at) a_bank = ~bank;
         a_ready = ($urandom_range(99) < duty);
         if (pv && !pr && !(a_valid === 1'b1 && a_data === pd && a_last === pl)) stab_err++;
         if (a_we !== 1'b0) we_err++;
         if (a_busy && a_rs !== bank) rs_err++;
         if (a_cs) begin
            if (int'(a_addr) != issued) addr_err++;
            issued++;
         end else if (issued > 0 && issued < 256) begin
            pauses++;
         end
         if (a_valid && a_ready) begin
            words.push_back(a_data);
            lasts.push_back(a_last);
         end
         pv = a_valid; pr = a_ready; pd = a_data; pl = a_last;
         if (a_done) begin
            if (a_busy) busy_err++;
            done_cnt++;
            if (done_j < 0) done_j = j;
            timeout = 1'b0;
            if (chain_out) begin
               a_start = 1'b1;
               a_bank  = bank;
               break;
            end
         end
         if (done_j >= 0 && j >= done_j + 3) break;
      end
   endtask

   task automatic applyStimulus_reset();
      rst_n = 1'b0;
      a_start = 0; a_bank = 0; a_ready = 0; a_rdata = 0;
      b_start = 0; b_bank = 0; b_ready = 0; b_rdata = 0;
      mem_a[0] = {32{8'hA5}};
      mem_a[1] = {32{8'h3C}};
      mem_b    = 16'h1FFF;
   endtask

   task automatic test_reset();
      applyStimulus_reset();
      #12;
      checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_valid got %b exp 0", a_valid); end
      checks++; if (a_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_m_data got %h exp 00", a_data); end
      checks++; if (a_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_last got %b exp 0", a_last); end
      checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy_done got %b%b exp 00", a_busy, a_done); end
      checks++; if (a_cs !== 1'b0 || a_we !== 1'b0 || a_rs !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_ctl got %b%b%b exp 000", a_cs, a_we, a_rs); end
      checks++; if (a_addr !== 8'h00) begin errors++; $display("[TB] FAIL rst_ram_address got %h exp 00", a_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      int bad, last_pos, last_cnt;
      drain(1'b0, 100, -1, 1'b0, 1'b0);
      checks++; if (timeout) begin errors++; $display("[TB] FAIL full_timeout got no done exp done"); end
      checks++; if (words.size() != 32) begin errors++; $display("[TB] FAIL full_count got %0d exp 32", words.size()); end
      bad = 0; last_pos = -1; last_cnt = 0;
      foreach (words[i]) begin
         if (words[i] !== 8'hA5) bad++;
         if (lasts[i]) begin last_pos = i; last_cnt++; end
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL full_data got %0d bad words exp 0", bad); end
      checks++; if (last_pos != 31 || last_cnt != 1) begin errors++; $display("[TB] FAIL full_last got pos %0d cnt %0d exp pos 31 cnt 1", last_pos, last_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL full_done_once got %0d exp 1", done_cnt); end
      checks++; if (done_j < 0 || done_j > 258) begin errors++; $display("[TB] FAIL full_latency got %0d exp <=258", done_j); end
      checks++; if (pauses != 0 || addr_err != 0 || issued != 256) begin errors++; $display("[TB] FAIL full_issue got pauses %0d addr_err %0d issued %0d exp 0 0 256", pauses, addr_err, issued); end
      checks++; if (we_err != 0 || busy_err != 0) begin errors++; $display("[TB] FAIL full_we_busy got %0d %0d exp 0 0", we_err, busy_err); end
   endtask

   task automatic test_ready_stall();
      int bad, last_pos;
      logic [7:0] exp_w;
      for (int i = 0; i < 8; i++) mem_a[0][32*i +: 32] = $urandom;
      drain(1'b0, 30, -1, 1'b0, 1'b0);
      checks++; if (words.size() != 32) begin errors++; $display("[TB] FAIL stall_count got %0d exp 32", words.size()); end
      bad = 0; last_pos = -1;
      foreach (words[i]) begin
         exp_w = mem_a[0][8*i +: 8];
         if (words[i] !== exp_w) bad++;
         if (lasts[i]) last_pos = i;
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL stall_data got %0d bad words exp 0", bad); end
      checks++; if (last_pos != 31) begin errors++; $display("[TB] FAIL stall_last got %0d exp 31", last_pos); end
      checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d unstable cycles exp 0", stab_err); end
      checks++; if (pauses == 0) begin errors++; $display("[TB] FAIL stall_cs_pause got %0d pauses exp >0", pauses); end
      checks++; if (addr_err != 0 || issued != 256) begin errors++; $display("[TB] FAIL stall_addr got err %0d issued %0d exp 0 256", addr_err, issued); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL stall_done got %0d exp 1", done_cnt); end
      mem_a[0] = {32{8'hA5}};
   endtask

   task automatic test_bank_select();
      int bad;
      drain(1'b1, 100, 20, 1'b0, 1'b0);
      checks++; if (rs_err != 0) begin errors++; $display("[TB] FAIL bank_rs got %0d bad cycles exp 0", rs_err); end
      checks++; if (words.size() != 32) begin errors++; $display("[TB] FAIL bank_count got %0d exp 32", words.size()); end
      bad = 0;
      foreach (words[i]) if (words[i] !== 8'h3C) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bank_data got %0d bad words exp 0", bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bank_done got %0d exp 1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      int n, bad;
      n = 0;
      @(negedge clk);
      a_start = 1'b1; a_bank = 1'b1; a_ready = 1'b1;
      for (int j = 0; j < 500 && n < 10; j++) begin
         @(negedge clk);
         a_start = 1'b0;
         if (a_valid && a_ready) n++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (n != 10) begin errors++; $display("[TB] FAIL mid_words got %0d exp 10", n); end
      checks++; if (a_valid !== 1'b0 || a_data !== 8'h00 || a_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_stream got v%b d%h l%b exp v0 d00 l0", a_valid, a_data, a_last); end
      checks++; if (a_busy !== 1'b0 || a_cs !== 1'b0 || a_rs !== 1'b0 || a_addr !== 8'h00) begin errors++; $display("[TB] FAIL mid_ctl got busy %b cs %b rs %b addr %h exp 0 0 0 00", a_busy, a_cs, a_rs, a_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      drain(1'b0, 100, -1, 1'b0, 1'b0);
      bad = 0;
      foreach (words[i]) if (words[i] !== 8'hA5) bad++;
      checks++; if (words.size() != 32 || bad != 0) begin errors++; $display("[TB] FAIL mid_redrain got %0d words %0d bad exp 32 0", words.size(), bad); end
      checks++; if (addr_err != 0 || issued != 256) begin errors++; $display("[TB] FAIL mid_addr got err %0d issued %0d exp 0 256", addr_err, issued); end
   endtask

   task automatic test_back_to_back();
      int bad;
      drain(1'b0, 100, -1, 1'b0, 1'b1);
      checks++; if (done_cnt != 1 || words.size() != 32) begin errors++; $display("[TB] FAIL b2b_first got done %0d words %0d exp 1 32", done_cnt, words.size()); end
      drain(1'b0, 100, -1, 1'b1, 1'b0);
      bad = 0;
      foreach (words[i]) if (words[i] !== 8'hA5) bad++;
      checks++; if (timeout || done_j > 258) begin errors++; $display("[TB] FAIL b2b_second_done got j %0d exp <=258", done_j); end
      checks++; if (words.size() != 32 || bad != 0) begin errors++; $display("[TB] FAIL b2b_second_data got %0d words %0d bad exp 32 0", words.size(), bad); end
   endtask

   // Drains dut_b (13-bit frame) and checks the two words against hand values.
   task automatic test_short_frame(input logic [15:0] pattern, input logic [7:0] exp0, input logic [7:0] exp1,
                                    input logic exp_par);
      logic [7:0] bw[$];
      logic       bl[$];
      logic       bp[$];
      bit         seen_done;
      mem_b = pattern;
      seen_done = 1'b0;
      @(negedge clk);
      b_start = 1'b1; b_bank = 1'b0; b_ready = 1'b1;
      for (int j = 0; j < 100 && !seen_done; j++) begin
         @(negedge clk);
         b_start = 1'b0;
         if (b_valid && b_ready) begin
            bw.push_back(b_data);
            bl.push_back(b_last);
`ifdef DEC_DRAIN_PARITY_EN
            bp.push_back(b_par);
`else
            bp.push_back(1'b0);
`endif
         end
         if (b_done) seen_done = 1'b1;
      end
      checks++; if (!seen_done || bw.size() != 2) begin errors++; $display("[TB] FAIL short_count got %0d words done %b exp 2 1", bw.size(), seen_done); end
      if (bw.size() == 2) begin
         checks++; if (bw[0] !== exp0 || bl[0] !== 1'b0) begin errors++; $display("[TB] FAIL short_word0 got %h last %b exp %h last 0", bw[0], bl[0], exp0); end
         checks++; if (bw[1] !== exp1 || bl[1] !== 1'b1) begin errors++; $display("[TB] FAIL short_word1 got %h last %b exp %h last 1", bw[1], bl[1], exp1); end
`ifdef DEC_DRAIN_PARITY_EN
         checks++; if (bp[0] !== 1'b0 || bp[1] !== exp_par) begin errors++; $display("[TB] FAIL short_parity got %b%b exp 0%b", bp[0], bp[1], exp_par); end
`endif
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got timeout exp finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_full_frame();
      test_ready_stall();
      test_bank_select();
      test_reset_mid();
      test_back_to_back();
      test_short_frame(16'h1FFF, 8'hFF, 8'h1F, 1'b1);
`ifdef DEC_DRAIN_PARITY_EN
      test_short_frame(16'h007F, 8'h7F, 8'h00, 1'b1);
      test_short_frame(16'h003F, 8'h3F, 8'h00, 1'b0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dec_ram_drain.md
DEC_RAM_DRAIN -- requirements
Module: dec_ram_drain

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: decision RAM address width.
REQ-002 SHALL have parameter FRAME_LEN, default 256: decoded bits per frame; legal range 1..2^ADDR_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 8: output word width; legal range 1..32.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1: one-cycle pulse requesting a frame drain.
REQ-007 SHALL have port start_bank, input, 1: bank to drain, sampled with start (0 = current, 1 = next).
REQ-008 SHALL have ports ram_address (output, ADDR_WIDTH), ram_cs (output, 1), ram_we (output, 1), ram_rs (output, 1): drive the decision RAM port.
REQ-009 SHALL have port ram_data, input, 1: RAM read data, valid one cycle after the address with ram_cs=1.
REQ-010 SHALL have ports m_data (output, OUT_WIDTH), m_valid (output, 1), m_last (output, 1), m_ready (input, 1): output stream.
REQ-011 SHALL have ports busy (output, 1), done (output, 1): drain in progress; one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, READ, FLUSH; IDLE->READ on start; READ->FLUSH after address FRAME_LEN-1 issued; FLUSH->IDLE when the final word is accepted.
REQ-013 SHALL ignore start when not in IDLE; no error is flagged.
REQ-014 SHALL latch start_bank into ram_rs on accepted start and hold it constant until IDLE is re-entered.
REQ-015 SHALL drive ram_we=0 at all times.
REQ-016 SHALL issue addresses 0..FRAME_LEN-1 ascending, at most one per cycle, with ram_cs=1 only in cycles issuing a read.
REQ-017 SHALL capture ram_data one cycle after each issued read and pack bits LSB-first (address k to bit k mod OUT_WIDTH).
REQ-018 SHALL present a word on m_valid when OUT_WIDTH bits are packed, or when the final frame bit is packed (upper bits zero-padded, m_last=1).
REQ-019 SHALL hold m_data, m_valid, m_last stable while m_valid=1 and m_ready=0; a transfer occurs when m_valid and m_ready are both 1.
REQ-020 SHALL provide one output holding register plus one packing register; SHALL stall address issue when an issued read would complete a word while the holding register is full and not being accepted in that cycle; no bit SHALL be lost or duplicated.
REQ-021 SHALL sustain one bit per cycle when m_ready is held 1.
REQ-022 SHALL pulse done for one cycle in the cycle after the m_last transfer; busy SHALL be 1 from the cycle after accepted start through the cycle before done.
REQ-023 SHALL support back-to-back frames: a start in the done cycle SHALL be accepted.
REQ-024 SHALL produce ceil(FRAME_LEN/OUT_WIDTH) words per frame; FRAME_LEN=1 yields one word with m_last=1.

Reset
REQ-025 SHALL, on rst_n=0, immediately force IDLE, ram_cs=0, ram_we=0, ram_rs=0, ram_address=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, and clear packing state.
REQ-026 SHALL discard any partial frame on reset mid-drain; after release the block waits for a new start.

Configuration
REQ-027 SHALL, with DEC_DRAIN_PARITY_EN defined, add output m_parity (1 bit) equal to XOR of all FRAME_LEN frame bits, valid with the m_last word and 0 otherwise.
REQ-028 SHALL, without DEC_DRAIN_PARITY_EN, omit m_parity and all parity logic; other behaviour is identical.

Verification
REQ-029 SHALL cover: bank 0 preloaded with 0xA5 repeating, FRAME_LEN=256, m_ready=1 -> 32 words of 0xA5, m_last on word 31, done once, 256+2 cycles start-to-done maximum.
REQ-030 SHALL cover: FRAME_LEN=13, OUT_WIDTH=8, all ones -> words 0xFF then 0x1F with m_last=1.
REQ-031 SHALL cover: m_ready random 30% duty -> stream equal to bank contents, data stable during stalls, ram_cs pauses.
REQ-032 SHALL cover: start_bank=1 with bank 1 differing from bank 0 -> ram_rs=1 throughout and bank 1 data output; start during busy ignored.
REQ-033 SHALL cover: rst_n pulsed low at word 10 -> outputs zero asynchronously, next start drains a full frame from address 0.
REQ-034 SHALL cover, with DEC_DRAIN_PARITY_EN: frame with 7 ones -> m_parity=1 on the m_last word only.
